// File: rtl/nios_7seg_display_ctrl.sv
// Avalon-MM seven-segment display controller: hex decode, per-digit dp, blanking
// and hardware blink, with a registered segment output per digit.
module nios_7seg_display_ctrl #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter int unsigned BLINK_DIV  = 25000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [NUM_DIGITS*8-1:0] seg_out
);

    localparam int unsigned VAL_W   = 4 * NUM_DIGITS;
    localparam int unsigned SEG_W   = 8 * NUM_DIGITS;
    localparam int unsigned CNT_W   = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BLINK_DIV - 1);
    localparam logic [7:0]       RST_DIGIT = ACTIVE_LOW ? 8'hC0 : 8'h3F;

    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
            $error("nios_7seg_display_ctrl: NUM_DIGITS must be 1..8");
        end
        if (BLINK_DIV < 2) begin : g_bad_div
            $error("nios_7seg_display_ctrl: BLINK_DIV must be at least 2");
        end
    endgenerate

    logic [VAL_W-1:0]      value_q, value_d;
    logic [NUM_DIGITS-1:0] dp_q, dp_d;
    logic [NUM_DIGITS-1:0] blank_q, blank_d;
    logic [NUM_DIGITS-1:0] blink_q, blink_d;
    logic                  en_q, en_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  phase_q, phase_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic                  wr_en_c;
    logic                  sync_c;
    logic [7:0]            lit_c;

    // Only the low 4N / N bits of writedata carry register content.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        case (v)
            4'h0: hex_decode = 7'h3F;
            4'h1: hex_decode = 7'h06;
            4'h2: hex_decode = 7'h5B;
            4'h3: hex_decode = 7'h4F;
            4'h4: hex_decode = 7'h66;
            4'h5: hex_decode = 7'h6D;
            4'h6: hex_decode = 7'h7D;
            4'h7: hex_decode = 7'h07;
            4'h8: hex_decode = 7'h7F;
            4'h9: hex_decode = 7'h6F;
            4'hA: hex_decode = 7'h77;
            4'hB: hex_decode = 7'h7C;
            4'hC: hex_decode = 7'h39;
            4'hD: hex_decode = 7'h5E;
            4'hE: hex_decode = 7'h79;
            default: hex_decode = 7'h71;
        endcase
    endfunction

    // Register writes and blink timer; a SYNC write outranks the wrap.
    always_comb begin
        value_d = value_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        blink_d = blink_q;
        en_d    = en_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        sync_c  = 1'b0;
        wr_en_c = chipselect & ~write_n;

        if (wr_en_c) begin
            case (address)
                3'd0: value_d = writedata[VAL_W-1:0];
                3'd1: dp_d    = writedata[NUM_DIGITS-1:0];
                3'd2: blank_d = writedata[NUM_DIGITS-1:0];
                3'd3: blink_d = writedata[NUM_DIGITS-1:0];
                3'd4: begin
                    en_d   = writedata[0];
                    sync_c = writedata[2];
                end
                default: ;
            endcase
        end

        if (sync_c) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Segment pattern from the current register state; lands on the pins next edge.
    always_comb begin
        seg_d = '0;
        lit_c = '0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            lit_c = {dp_q[k], hex_decode(value_q[4*k +: 4])};
            if (!en_q || blank_q[k] || (blink_q[k] && phase_q)) begin
                lit_c = 8'h00;
            end
            seg_d[8*k +: 8] = ACTIVE_LOW ? ~lit_c : lit_c;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            3'd0: readdata = 32'(value_q);
            3'd1: readdata = 32'(dp_q);
            3'd2: readdata = 32'(blank_q);
            3'd3: readdata = 32'(blink_q);
            3'd4: readdata = {29'd0, 1'b0, phase_q, en_q};
            default: readdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
            dp_q    <= '0;
            blank_q <= '0;
            blink_q <= '0;
            en_q    <= 1'b1;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            seg_q   <= {NUM_DIGITS{RST_DIGIT}};
        end else begin
            value_q <= value_d;
            dp_q    <= dp_d;
            blank_q <= blank_d;
            blink_q <= blink_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
        end
    end

    assign seg_out = seg_q;

endmodule

// File: doc/nios_7seg_display_ctrl.md
Name: nios_7seg_display_ctrl

Overview:
Parametrised Avalon-MM slave that drives NUM_DIGITS seven-segment digits from one register bank, the next generation of the single-register 7-seg GPIO output port. It adds hex decode, per-digit decimal point, blanking and hardware blink, so software writes 4-bit digit values instead of raw segment patterns. It sits on the Nios/HPS lightweight bus, with seg_out wired to the board HEX displays.

Parameters:
NUM_DIGITS, 6, number of digits driven; legal range 1..8.
ACTIVE_LOW, 1, 1 = segments lit when driven 0, as on the DE-series boards; 0 = active-high.
BLINK_DIV, 25000000, clk cycles per blink half-period; must be at least 2.

Ports:
clk  in  1  system clock, single domain
reset  in  1  asynchronous, active-high reset
address  in  3  word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, combinational, zero read latency
seg_out  out  NUM_DIGITS*8  digit k at bits [8k+7:8k]; bit 7 = dp, bits 6..0 = segments g..a

Behaviour:
- A write occurs when chipselect=1 and write_n=0. Registers update on the same clk edge. Writes to address 5..7 are ignored.
- Register map (N = NUM_DIGITS):
  - addr 0 VALUE[4N-1:0]: nibble k is the hex value of digit k.
  - addr 1 DP[N-1:0]: decimal-point enable per digit.
  - addr 2 BLANK[N-1:0]: 1 forces the digit fully off, dp included.
  - addr 3 BLINK[N-1:0]: 1 makes the digit blink.
  - addr 4 CTRL: bit0 EN (global display enable); bit1 PHASE (read-only current blink phase); bit2 SYNC (write-1 pulse, always reads 0).
- Readdata returns the register at the addressed location, zero-extended; unused bits and addresses 5..7 read 0. Readdata is valid while chipselect=1; its value when chipselect=0 is don't-care.
- Reset values:
  - VALUE=0, DP=0, BLANK=0, BLINK=0, EN=1.
  - Blink counter=0, phase=0.
  - seg_out shows every digit as "0" without dp (0x3F per digit, or 0xC0 per digit when ACTIVE_LOW=1). This is the registered decode of the reset state.
- Blink timer:
  - Counter runs 0..BLINK_DIV-1. On the wrap cycle it returns to 0 and phase toggles.
  - A write to CTRL with bit2=1 clears the counter and phase on that edge; this takes priority over the wrap.
  - The counter free-runs regardless of EN.
- Decode table (g..a), values 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Per-digit lit pattern = {DP[k], decode(VALUE nibble k)}. This pattern is forced to 0x00 if EN=0, or BLANK[k]=1, or (BLINK[k]=1 and phase=1).
- Output is the lit pattern, inverted when ACTIVE_LOW=1. seg_out is registered: exactly 1 clk of latency from a register write or phase change to the pin.
- Simultaneous events: a write and a phase toggle on the same edge are both applied; the output one cycle later reflects both.
- Reset asserted mid-operation: all state returns to reset values immediately, asynchronously, seg_out included.
- Parameter check: NUM_DIGITS > 8 is a synthesis-time error.

Test Plan:
1. Reset release, ACTIVE_LOW=1, N=6 -> seg_out = 48'hC0C0C0C0C0C0; readdata from address 4 = 0x1.
2. Write VALUE=0x00A1B2, DP=0x01, then read back -> the edge after the VALUE write gives digit0=~0x5B=0xA4; after the DP write digit0=0x24, digit1=~0x7C=0x83, digit3=~0x77=0x88. Readback address 0 = 0x00A1B2, address 1 = 0x01.
3. BLINK_DIV=4, BLINK=0x02, SYNC written -> digit1 toggles off/on every 4 clk (off = 0xFF in active-low). Other digits stay steady. Address 4 bit1 tracks the phase.
4. BLANK=0x3F, then CTRL EN=0 with BLANK=0 -> all digits read 0xFF in both cases. Writing EN=1 restores the decoded values one clk later.
5. SYNC written on the same edge the counter wraps -> counter=0 and phase=0 after that edge (no toggle). A write to address 6 leaves all registers unchanged, and reads of addresses 5..7 return 0.
6. Assert reset asynchronously mid-blink with VALUE=0xFFFFFF -> seg_out returns to 0xC0 per digit without waiting for a clk edge.
